// File: rtl/can_pkg.sv
// Shared CAN transmit definitions: scheduler FSM encoding, message width and field slices.
package can_pkg;

    localparam int CAN_MSG_W = 128;

    localparam int CAN_ID_MSB  = 127;
    localparam int CAN_ID_LSB  = 96;
    localparam int CAN_DLC_MSB = 95;
    localparam int CAN_DLC_LSB = 64;
    localparam int CAN_DW1_MSB = 63;
    localparam int CAN_DW1_LSB = 32;
    localparam int CAN_DW2_MSB = 31;
    localparam int CAN_DW2_LSB = 0;

    typedef logic [CAN_MSG_W-1:0] can_msg_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_BUS = 3'd2,
        REQ      = 3'd3,
        ACTIVE   = 3'd4
    } can_tx_state_t;

    function automatic can_msg_t can_pack(input logic [31:0] id, input logic [31:0] dlc,
                                          input logic [31:0] dw1, input logic [31:0] dw2);
        can_msg_t m;
        m = '0;
        m[CAN_ID_MSB:CAN_ID_LSB]   = id;
        m[CAN_DLC_MSB:CAN_DLC_LSB] = dlc;
        m[CAN_DW1_MSB:CAN_DW1_LSB] = dw1;
        m[CAN_DW2_MSB:CAN_DW2_LSB] = dw2;
        return m;
    endfunction

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Scheduler-facing bundle: message sources, bus status, BSP request/outcome handshake.
interface can_tx_scheduler_if;
    import can_pkg::*;

    logic     i_cen;
    logic     i_sleep;
    logic     i_bsoff;
    logic     i_hpb_full;
    can_msg_t i_hpb_data;
    logic     i_tx_empty;
    can_msg_t i_tx_fifo_data;
    logic     o_hpb_r_en;
    logic     o_tx_r_en;
    logic     i_bidle;
    can_msg_t o_msg_data;
    logic     o_msg_valid;
    logic     i_msg_ack;
    logic     i_txok;
    logic     i_arblst;
    logic     i_tx_error;
    logic     o_busy;
    logic     o_tx_abort;

    // master is the scheduler itself; slave is the surrounding controller/BSP side
    modport master (
        input  i_cen, i_sleep, i_bsoff, i_hpb_full, i_hpb_data, i_tx_empty, i_tx_fifo_data,
               i_bidle, i_msg_ack, i_txok, i_arblst, i_tx_error,
        output o_hpb_r_en, o_tx_r_en, o_msg_data, o_msg_valid, o_busy, o_tx_abort
    );

    modport slave (
        output i_cen, i_sleep, i_bsoff, i_hpb_full, i_hpb_data, i_tx_empty, i_tx_fifo_data,
               i_bidle, i_msg_ack, i_txok, i_arblst, i_tx_error,
        input  o_hpb_r_en, o_tx_r_en, o_msg_data, o_msg_valid, o_busy, o_tx_abort
    );

endinterface

// File: rtl/can_tx_retry_counter.sv
// Counts failed transmit attempts of the held message; last flags the final permitted attempt.
module can_tx_retry_counter #(
    parameter int MAX_RETRIES = 8
) (
    input  logic i_sys_clk,
    input  logic i_reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(MAX_RETRIES + 1);

    logic [CW-1:0] count;

    assign last = (count == CW'(MAX_RETRIES - 1));

    // wrapping to zero on the final failure lets the aborted message leave with a clean count
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (clr || (inc && last)) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Picks HPB-then-FIFO messages, holds one for the BSP and retransmits it on loss/error until sent.
// Define CAN_TX_RETRY_LIMIT_EN to drop a message after MAX_RETRIES failed attempts.
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int MAX_RETRIES = 8
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset,
    can_tx_scheduler_if.master   bus
);

    can_tx_state_t state;
    can_tx_state_t state_nxt;
    logic          src_hpb;
    logic          abort_cond;
    logic          start;
    logic          tx_fail;
    logic          fail_inc;
    logic          retry_exhausted;

    assign abort_cond = (state != IDLE) && (bus.i_bsoff || !bus.i_cen);
    assign start      = bus.i_cen && !bus.i_sleep && !bus.i_bsoff &&
                        (bus.i_hpb_full || !bus.i_tx_empty);
    assign tx_fail    = bus.i_arblst || bus.i_tx_error;
    // a successful transmission wins over a simultaneous loss/error report
    assign fail_inc   = (state == ACTIVE) && !bus.i_txok && tx_fail && !abort_cond;

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic retry_last;

    can_tx_retry_counter #(
        .MAX_RETRIES (MAX_RETRIES)
    ) u_retry (
        .i_sys_clk (i_sys_clk),
        .i_reset   (i_reset),
        .clr       ((state == IDLE) && (state_nxt == LOAD)),
        .inc       (fail_inc),
        .last      (retry_last)
    );

    assign retry_exhausted = fail_inc && retry_last;
`else
    assign retry_exhausted = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = LOAD;
            LOAD:     state_nxt = WAIT_BUS;
            WAIT_BUS: if (bus.i_bidle) state_nxt = REQ;
            REQ:      if (bus.i_msg_ack) state_nxt = ACTIVE;
            ACTIVE: begin
                if (bus.i_txok)           state_nxt = IDLE;
                else if (retry_exhausted) state_nxt = IDLE;
                else if (tx_fail)         state_nxt = WAIT_BUS;
            end
            default:  state_nxt = IDLE;
        endcase
        if (abort_cond) state_nxt = IDLE;
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            src_hpb        <= 1'b0;
            bus.o_msg_data <= '0;
            bus.o_tx_abort <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.o_tx_abort <= abort_cond || retry_exhausted;
            if (state == IDLE) begin
                src_hpb <= bus.i_hpb_full;
            end
            if ((state == LOAD) && !abort_cond) begin
                bus.o_msg_data <= src_hpb ? bus.i_hpb_data : bus.i_tx_fifo_data;
            end
        end
    end

    // no strobe while aborting, so the source keeps a message that would only be discarded
    assign bus.o_hpb_r_en  = (state == LOAD) && src_hpb && !abort_cond;
    assign bus.o_tx_r_en   = (state == LOAD) && !src_hpb && !abort_cond;
    assign bus.o_msg_valid = (state == REQ);
    assign bus.o_busy      = (state != IDLE);

    always @(posedge i_sys_clk) begin
        if (!i_reset) begin
            assert (MAX_RETRIES > 0 && !(bus.o_hpb_r_en && bus.o_tx_r_en));
        end
    end

endmodule
